// File: rtl/commit_trace.sv
// Retirement trace buffer: captures committed instructions into a small FIFO
// while tracing is enabled, stopping for good once the halt instruction retires.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | tracing off; buffer keeps draining, commits ignored
// S_RUN    | tracing on; commits captured, cycle_cnt advancing
// S_HALTED | halt instruction captured; drains only, left only by reset
module commit_trace #(
    parameter int          XLEN      = 32,
    parameter int          DEPTH     = 16,
    parameter bit          WRAP_MODE = 1'b0,
    parameter logic [31:0] HALT_INS  = 32'h00100073
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_en,
    input  logic                     i_commit_valid,
    input  logic [XLEN-1:0]          i_commit_pc,
    input  logic [31:0]              i_commit_ins,
    input  logic                     i_rf_we,
    input  logic [4:0]               i_rf_rd,
    input  logic [XLEN-1:0]          i_rf_wdata,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [XLEN-1:0]          o_out_pc,
    output logic [31:0]              o_out_ins,
    output logic                     o_out_we,
    output logic [4:0]               o_out_rd,
    output logic [XLEN-1:0]          o_out_wdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [15:0]              o_drop_cnt,
    output logic [31:0]              o_cycle_cnt,
    output logic                     o_halted,
    output logic                     o_done
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              CW       = AW + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [XLEN-1:0] r_mem_pc    [DEPTH];
    logic [31:0]     r_mem_ins   [DEPTH];
    logic            r_mem_we    [DEPTH];
    logic [4:0]      r_mem_rd    [DEPTH];
    logic [XLEN-1:0] r_mem_wdata [DEPTH];

    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [15:0]     r_drop_cnt;
    logic [31:0]     r_cycle_cnt;

    logic            w_run;
    logic            w_halted;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_wr;
    logic            w_drop;
    logic            w_rd_adv;
    logic            w_is_halt;
    logic            w_we_eff;
    logic [4:0]      w_rd_eff;
    logic [XLEN-1:0] w_wdata_eff;

    // ---------------- state machine ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A captured halt wins over en falling on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_en) w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_push && w_is_halt) w_state_nxt = S_HALTED;
                else if (!i_en)          w_state_nxt = S_IDLE;
            end
            S_HALTED: w_state_nxt = S_HALTED;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_run    = 1'b0;
        w_halted = 1'b0;
        case (r_state)
            S_RUN:    w_run    = 1'b1;
            S_HALTED: w_halted = 1'b1;
            default: ;
        endcase
    end

    // ---------------- buffer control ----------------
    assign w_is_halt   = (i_commit_ins == HALT_INS);
    assign w_push      = w_run && i_commit_valid;
    assign w_pop       = o_out_valid && i_out_ready;
    assign w_full      = (r_count == FULL_CNT);

    // When full, a simultaneous pop frees the slot the write pointer sits on.
    assign w_drop      = w_push && w_full && !w_pop;
    assign w_wr        = w_push && (!w_full || w_pop || (WRAP_MODE == 1'b1));
    assign w_rd_adv    = w_pop || (w_drop && (WRAP_MODE == 1'b1));

    assign w_we_eff    = i_rf_we && (i_rf_rd != 5'd0);
    assign w_rd_eff    = w_we_eff ? i_rf_rd    : 5'd0;
    assign w_wdata_eff = w_we_eff ? i_rf_wdata : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_drop_cnt  <= '0;
            r_cycle_cnt <= '0;
        end else begin
            if (w_wr)     r_wptr <= r_wptr + 1'b1;
            if (w_rd_adv) r_rptr <= r_rptr + 1'b1;
            if (w_wr && !w_rd_adv)      r_count <= r_count + 1'b1;
            else if (!w_wr && w_rd_adv) r_count <= r_count - 1'b1;
            if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
            if (w_run) r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    // Storage is not reset; emptiness is tracked by r_count alone.
    always_ff @(posedge i_clk) begin
        if (w_wr && !i_rst) begin
            r_mem_pc[r_wptr]    <= i_commit_pc;
            r_mem_ins[r_wptr]   <= i_commit_ins;
            r_mem_we[r_wptr]    <= w_we_eff;
            r_mem_rd[r_wptr]    <= w_rd_eff;
            r_mem_wdata[r_wptr] <= w_wdata_eff;
        end
    end

    // ---------------- outputs ----------------
    assign o_out_valid = (r_count != '0);
    assign o_out_pc    = r_mem_pc[r_rptr];
    assign o_out_ins   = r_mem_ins[r_rptr];
    assign o_out_we    = r_mem_we[r_rptr];
    assign o_out_rd    = r_mem_rd[r_rptr];
    assign o_out_wdata = r_mem_wdata[r_rptr];
    assign o_count     = r_count;
    assign o_drop_cnt  = r_drop_cnt;
    assign o_cycle_cnt = r_cycle_cnt;
    assign o_halted    = w_halted;
    assign o_done      = w_halted && (r_count == '0);

endmodule

// File: tb/tb_commit_trace.sv
// Directed bench for commit_trace: two DEPTH=4 instances (drop-newest and
// overwrite-oldest) share one stimulus stream.
module tb_commit_trace;

    localparam logic [31:0] HALT = 32'h00100073;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        en;
    logic        cv;
    logic [31:0] cpc;
    logic [31:0] cins;
    logic        rwe;
    logic [4:0]  rrd;
    logic [31:0] rwd;
    logic        ordy;

    logic        w0_valid, w1_valid;
    logic [31:0] w0_pc, w1_pc;
    logic [31:0] w0_ins, w1_ins;
    logic        w0_we, w1_we;
    logic [4:0]  w0_rd, w1_rd;
    logic [31:0] w0_wd, w1_wd;
    logic [2:0]  w0_cnt, w1_cnt;
    logic [15:0] w0_drop, w1_drop;
    logic [31:0] w0_cyc, w1_cyc;
    logic        w0_halt, w1_halt;
    logic        w0_done, w1_done;

    int n_cmp;
    int n_err;

    commit_trace #(.XLEN(32), .DEPTH(4), .WRAP_MODE(1'b0), .HALT_INS(HALT)) u_w0 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_commit_valid(cv), .i_commit_pc(cpc),
        .i_commit_ins(cins), .i_rf_we(rwe), .i_rf_rd(rrd), .i_rf_wdata(rwd),
        .o_out_valid(w0_valid), .i_out_ready(ordy), .o_out_pc(w0_pc), .o_out_ins(w0_ins),
        .o_out_we(w0_we), .o_out_rd(w0_rd), .o_out_wdata(w0_wd), .o_count(w0_cnt),
        .o_drop_cnt(w0_drop), .o_cycle_cnt(w0_cyc), .o_halted(w0_halt), .o_done(w0_done)
    );

    commit_trace #(.XLEN(32), .DEPTH(4), .WRAP_MODE(1'b1), .HALT_INS(HALT)) u_w1 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_commit_valid(cv), .i_commit_pc(cpc),
        .i_commit_ins(cins), .i_rf_we(rwe), .i_rf_rd(rrd), .i_rf_wdata(rwd),
        .o_out_valid(w1_valid), .i_out_ready(ordy), .o_out_pc(w1_pc), .o_out_ins(w1_ins),
        .o_out_we(w1_we), .o_out_rd(w1_rd), .o_out_wdata(w1_wd), .o_count(w1_cnt),
        .o_drop_cnt(w1_drop), .o_cycle_cnt(w1_cyc), .o_halted(w1_halt), .o_done(w1_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; cv = 1'b0; ordy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents one commit for exactly one rising edge; leaves cv asserted.
    task automatic drive_commit(input logic [31:0] pc, input logic [31:0] ins,
                                input logic we, input logic [4:0] rd, input logic [31:0] wd);
        cv = 1'b1; cpc = pc; cins = ins; rwe = we; rrd = rd; rwd = wd;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; cv = 1'b0; ordy = 1'b0;
        cpc = '0; cins = NOP; rwe = 1'b0; rrd = '0; rwd = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (w0_cnt !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", w0_cnt); end
        n_cmp++; if (w0_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", w0_valid); end
        n_cmp++; if (w0_drop !== 16'd0) begin n_err++; $display("FAIL reset_drop got %0d exp 0", w0_drop); end
        n_cmp++; if (w0_cyc !== 32'd0) begin n_err++; $display("FAIL reset_cycle got %0d exp 0", w0_cyc); end
        n_cmp++; if (w0_halt !== 1'b0 || w0_done !== 1'b0) begin n_err++; $display("FAIL reset_halt_done got %b%b exp 00", w0_halt, w0_done); end
    endtask

    task automatic test_latency();
        do_reset();
        en = 1'b1;
        @(negedge clk);
        drive_commit(32'h100, NOP, 1'b1, 5'd3, 32'h33);
        cv = 1'b0;
        n_cmp++; if (w0_valid !== 1'b1 || w0_pc !== 32'h100) begin n_err++; $display("FAIL latency_next got valid=%b pc=%0h exp valid=1 pc=100", w0_valid, w0_pc); end
        do_reset();
        en = 1'b1;
        @(negedge clk);
        cv = 1'b1; cpc = 32'h104; cins = NOP; rwe = 1'b0;
        #1;
        n_cmp++; if (w0_valid !== 1'b0) begin n_err++; $display("FAIL latency_bypass got %b exp 0", w0_valid); end
        @(negedge clk);
        cv = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        en = 1'b1;
        @(negedge clk);
        drive_commit(32'h0, 32'h00100293, 1'b1, 5'd5, 32'd1);
        drive_commit(32'h4, 32'h00200313, 1'b1, 5'd6, 32'd2);
        drive_commit(32'h8, 32'h00700013, 1'b1, 5'd0, 32'd7);
        cv = 1'b0;
        n_cmp++; if (w0_cnt !== 3'd3) begin n_err++; $display("FAIL basic_count got %0d exp 3", w0_cnt); end
        ordy = 1'b1;
        n_cmp++; if (w0_pc !== 32'h0 || w0_we !== 1'b1 || w0_rd !== 5'd5 || w0_wd !== 32'd1 || w0_ins !== 32'h00100293)
            begin n_err++; $display("FAIL basic_e0 got pc=%0h we=%b rd=%0d wd=%0h ins=%h exp 0/1/5/1/00100293", w0_pc, w0_we, w0_rd, w0_wd, w0_ins); end
        @(negedge clk);
        n_cmp++; if (w0_pc !== 32'h4 || w0_we !== 1'b1 || w0_rd !== 5'd6 || w0_wd !== 32'd2)
            begin n_err++; $display("FAIL basic_e1 got pc=%0h we=%b rd=%0d wd=%0h exp 4/1/6/2", w0_pc, w0_we, w0_rd, w0_wd); end
        @(negedge clk);
        n_cmp++; if (w0_pc !== 32'h8 || w0_we !== 1'b0 || w0_rd !== 5'd0 || w0_wd !== 32'd0)
            begin n_err++; $display("FAIL basic_e2 got pc=%0h we=%b rd=%0d wd=%0h exp 8/0/0/0", w0_pc, w0_we, w0_rd, w0_wd); end
        @(negedge clk);
        ordy = 1'b0;
        n_cmp++; if (w0_cnt !== 3'd0 || w0_valid !== 1'b0) begin n_err++; $display("FAIL basic_empty got cnt=%0d valid=%b exp 0/0", w0_cnt, w0_valid); end
    endtask

    task automatic test_full_modes();
        logic [31:0] exp0 [4];
        logic [31:0] exp1 [4];
        exp0 = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp1 = '{32'h8, 32'hC, 32'h10, 32'h14};
        do_reset();
        en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) drive_commit(32'(i * 4), NOP, 1'b1, 5'd1, 32'(i));
        cv = 1'b0;
        n_cmp++; if (w0_cnt !== 3'd4 || w0_drop !== 16'd2) begin n_err++; $display("FAIL stop_full got cnt=%0d drop=%0d exp 4/2", w0_cnt, w0_drop); end
        n_cmp++; if (w1_cnt !== 3'd4 || w1_drop !== 16'd2) begin n_err++; $display("FAIL wrap_full got cnt=%0d drop=%0d exp 4/2", w1_cnt, w1_drop); end
        ordy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (w0_pc !== exp0[i]) begin n_err++; $display("FAIL stop_drain[%0d] got pc=%0h exp %0h", i, w0_pc, exp0[i]); end
            n_cmp++; if (w1_pc !== exp1[i]) begin n_err++; $display("FAIL wrap_drain[%0d] got pc=%0h exp %0h", i, w1_pc, exp1[i]); end
            @(negedge clk);
        end
        ordy = 1'b0;
        n_cmp++; if (w0_cnt !== 3'd0 || w1_cnt !== 3'd0) begin n_err++; $display("FAIL modes_empty got %0d/%0d exp 0/0", w0_cnt, w1_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp0 [4];
        exp0 = '{32'h4, 32'h8, 32'hC, 32'h40};
        do_reset();
        en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) drive_commit(32'(i * 4), NOP, 1'b0, 5'd0, 32'd0);
        n_cmp++; if (w0_cnt !== 3'd4 || w0_pc !== 32'h0) begin n_err++; $display("FAIL pp_prefill got cnt=%0d pc=%0h exp 4/0", w0_cnt, w0_pc); end
        ordy = 1'b1;
        drive_commit(32'h40, NOP, 1'b0, 5'd0, 32'd0);
        cv = 1'b0; ordy = 1'b0;
        n_cmp++; if (w0_cnt !== 3'd4 || w0_drop !== 16'd0 || w0_pc !== 32'h4)
            begin n_err++; $display("FAIL pp_stop got cnt=%0d drop=%0d pc=%0h exp 4/0/4", w0_cnt, w0_drop, w0_pc); end
        n_cmp++; if (w1_cnt !== 3'd4 || w1_drop !== 16'd0 || w1_pc !== 32'h4)
            begin n_err++; $display("FAIL pp_wrap got cnt=%0d drop=%0d pc=%0h exp 4/0/4", w1_cnt, w1_drop, w1_pc); end
        @(negedge clk);
        n_cmp++; if (w0_pc !== 32'h4) begin n_err++; $display("FAIL pp_stable got pc=%0h exp 4", w0_pc); end
        ordy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (w0_pc !== exp0[i]) begin n_err++; $display("FAIL pp_drain[%0d] got pc=%0h exp %0h", i, w0_pc, exp0[i]); end
            @(negedge clk);
        end
        ordy = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        en = 1'b1;
        @(negedge clk);
        drive_commit(32'h14, NOP, 1'b0, 5'd0, 32'd0);
        drive_commit(32'h18, NOP, 1'b0, 5'd0, 32'd0);
        drive_commit(32'h1C, HALT, 1'b0, 5'd0, 32'd0);
        n_cmp++; if (w0_halt !== 1'b1 || w0_done !== 1'b0) begin n_err++; $display("FAIL halt_flag got halted=%b done=%b exp 1/0", w0_halt, w0_done); end
        drive_commit(32'h20, NOP, 1'b0, 5'd0, 32'd0);
        drive_commit(32'h24, NOP, 1'b0, 5'd0, 32'd0);
        cv = 1'b0;
        n_cmp++; if (w0_cnt !== 3'd3 || w0_drop !== 16'd0) begin n_err++; $display("FAIL halt_ignored got cnt=%0d drop=%0d exp 3/0", w0_cnt, w0_drop); end
        ordy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (w0_pc !== 32'h1C || w0_ins !== HALT) begin n_err++; $display("FAIL halt_last got pc=%0h ins=%h exp 1c/%h", w0_pc, w0_ins, HALT); end
        @(negedge clk);
        ordy = 1'b0;
        n_cmp++; if (w0_cnt !== 3'd0 || w0_done !== 1'b1 || w0_halt !== 1'b1)
            begin n_err++; $display("FAIL halt_done got cnt=%0d done=%b halted=%b exp 0/1/1", w0_cnt, w0_done, w0_halt); end
    endtask

    task automatic test_cycle_cnt();
        do_reset();
        en = 1'b1;
        @(negedge clk);
        n_cmp++; if (w0_cyc !== 32'd0) begin n_err++; $display("FAIL cyc_start got %0d exp 0", w0_cyc); end
        repeat (5) @(negedge clk);
        n_cmp++; if (w0_cyc !== 32'd5) begin n_err++; $display("FAIL cyc_run got %0d exp 5", w0_cyc); end
        en = 1'b0;
        drive_commit(32'h200, NOP, 1'b0, 5'd0, 32'd0);
        cv = 1'b0;
        n_cmp++; if (w0_cyc !== 32'd6 || w0_cnt !== 3'd1) begin n_err++; $display("FAIL en_fall got cyc=%0d cnt=%0d exp 6/1", w0_cyc, w0_cnt); end
        drive_commit(32'h300, NOP, 1'b0, 5'd0, 32'd0);
        cv = 1'b0;
        n_cmp++; if (w0_cyc !== 32'd6 || w0_cnt !== 3'd1 || w0_drop !== 16'd0)
            begin n_err++; $display("FAIL idle_ignore got cyc=%0d cnt=%0d drop=%0d exp 6/1/0", w0_cyc, w0_cnt, w0_drop); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) drive_commit(32'(16 * i), NOP, 1'b1, 5'd2, 32'd9);
        cv = 1'b0;
        n_cmp++; if (w0_cnt !== 3'd3) begin n_err++; $display("FAIL mid_prefill got %0d exp 3", w0_cnt); end
        rst = 1'b1; en = 1'b0; cv = 1'b1; cpc = 32'h77; ordy = 1'b1;
        @(negedge clk);
        rst = 1'b0; cv = 1'b0; ordy = 1'b0;
        n_cmp++; if (w0_cnt !== 3'd0 || w0_valid !== 1'b0 || w0_cyc !== 32'd0 || w0_halt !== 1'b0)
            begin n_err++; $display("FAIL mid_reset got cnt=%0d valid=%b cyc=%0d halted=%b exp 0/0/0/0", w0_cnt, w0_valid, w0_cyc, w0_halt); end
        @(negedge clk);
        n_cmp++; if (w0_cyc !== 32'd0 || w0_cnt !== 3'd0) begin n_err++; $display("FAIL mid_idle got cyc=%0d cnt=%0d exp 0/0", w0_cyc, w0_cnt); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_latency();
        test_basic();
        test_full_modes();
        test_back_to_back();
        test_halt();
        test_cycle_cnt();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
